// File: rtl/truth_table_sweeper_if.sv
// Handshake/result bundle between the truth-table sweeper and the function blocks
// under comparison. master = sweeper side, slave = stimulus/function side.
interface truth_table_sweeper_if #(
    parameter int N_IN = 4
);
    logic                  start;
    logic [N_IN-1:0]       vec;
    logic                  sa;
    logic                  sb;
    logic                  busy;
    logic                  done;
    logic [2**N_IN-1:0]    mask_a;
    logic [2**N_IN-1:0]    mask_b;
    logic [N_IN:0]         mismatch_cnt;
    logic [N_IN-1:0]       first_mm;
    logic                  equal;

    modport master (
        input  start, sa, sb,
        output vec, busy, done, mask_a, mask_b, mismatch_cnt, first_mm, equal
    );

    modport slave (
        output start, sa, sb,
        input  vec, busy, done, mask_a, mask_b, mismatch_cnt, first_mm, equal
    );
endinterface

// File: rtl/truth_table_sweeper.sv
// Sweeps every input vector in ascending order into two implementations of one
// function, captures both outputs as minterm masks and tallies disagreements.
module truth_table_sweeper #(
    parameter int N_IN   = 4,
    parameter int SETTLE = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    truth_table_sweeper_if.master  bus
);
    localparam int NVEC = 2**N_IN;
    localparam int CW   = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [N_IN-1:0] VEC_MAX     = '1;
    localparam logic [CW-1:0]   SETTLE_LAST = CW'(SETTLE - 1);

    typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;

    state_t             state;
    logic [CW-1:0]      settle_cnt;
    logic [N_IN-1:0]    vec_r;
    logic [NVEC-1:0]    mask_a_r;
    logic [NVEC-1:0]    mask_b_r;
    logic [N_IN:0]      mm_cnt_r;
    logic [N_IN-1:0]    first_mm_r;
    logic               busy_r;
    logic               done_r;
    logic               equal_r;

    logic               launch;
    logic               mm_now;
    logic [N_IN:0]      mm_cnt_next;

    // start only counts when no sweep is running; DONE restarts like IDLE
    assign launch      = bus.start && (state == IDLE || state == DONE);
    assign mm_now      = bus.sa ^ bus.sb;
    assign mm_cnt_next = mm_cnt_r + {{N_IN{1'b0}}, mm_now};

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            settle_cnt <= '0;
            vec_r      <= '0;
            mask_a_r   <= '0;
            mask_b_r   <= '0;
            mm_cnt_r   <= '0;
            first_mm_r <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            equal_r    <= 1'b0;
        end else if (launch) begin
            state      <= APPLY;
            settle_cnt <= '0;
            vec_r      <= '0;
            mask_a_r   <= '0;
            mask_b_r   <= '0;
            mm_cnt_r   <= '0;
            first_mm_r <= '0;
            busy_r     <= 1'b1;
            done_r     <= 1'b0;
            equal_r    <= 1'b0;
        end else begin
            case (state)
                APPLY: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state <= SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                SAMPLE: begin
                    mask_a_r[vec_r] <= bus.sa;
                    mask_b_r[vec_r] <= bus.sb;
                    if (mm_now) begin
                        mm_cnt_r <= mm_cnt_next;
                        if (mm_cnt_r == '0) begin
                            first_mm_r <= vec_r;
                        end
                    end
                    // last vector: hold vec at max rather than wrapping
                    if (vec_r == VEC_MAX) begin
                        state   <= DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        equal_r <= (mm_cnt_next == '0);
                    end else begin
                        vec_r      <= vec_r + 1'b1;
                        settle_cnt <= '0;
                        state      <= APPLY;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.vec          = vec_r;
    assign bus.mask_a       = mask_a_r;
    assign bus.mask_b       = mask_b_r;
    assign bus.mismatch_cnt = mm_cnt_r;
    assign bus.first_mm     = first_mm_r;
    assign bus.busy         = busy_r;
    assign bus.done         = done_r;
    assign bus.equal        = equal_r;
endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: table-driven sweeps, hand sequences for reset/start
// corner cases, and random truth tables checked against a whole-table model.
module tb_truth_table_sweeper;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    truth_table_sweeper_if #(.N_IN(4)) ifc1();
    truth_table_sweeper_if #(.N_IN(4)) ifc3();

    logic [15:0] ta1, tb1, ta3, tb3;
    assign ifc1.sa = ta1[ifc1.vec];
    assign ifc1.sb = tb1[ifc1.vec];
    assign ifc3.sa = ta3[ifc3.vec];
    assign ifc3.sb = tb3[ifc3.vec];

    truth_table_sweeper #(.N_IN(4), .SETTLE(1)) dut1 (.clk(clk), .reset(reset), .bus(ifc1));
    truth_table_sweeper #(.N_IN(4), .SETTLE(3)) dut3 (.clk(clk), .reset(reset), .bus(ifc3));

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       name;
        logic [15:0] ta;
        logic [15:0] tb;
        logic [15:0] exp_a;
        logic [15:0] exp_b;
        int          exp_cnt;
        int          exp_first;
        logic        exp_eq;
    } rec_t;

    rec_t tbl[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic f_simpl(input logic [3:0] v);
        logic x, y, z;
        x = v[3]; y = v[2]; z = v[0];
        return (x | y | ~z) & (x | ~y | ~z) & (~x | ~y | ~z);
    endfunction

    // Whole-table reference: disagreement count and lowest disagreeing vector
    task automatic model(input logic [15:0] a, input logic [15:0] b,
                         output int cnt, output int first);
        logic [15:0] d;
        d = a ^ b;
        cnt = $countones(d);
        first = 0;
        for (int i = 15; i >= 0; i--) if (d[i]) first = i;
    endtask

    // Runs one SETTLE=1 sweep; optionally pulses start once when vec==poke mid-sweep
    task automatic sweep1(input logic [15:0] a, input logic [15:0] b, input int poke,
                          output int cyc);
        bit poked;
        poked = 0;
        ta1 = a; tb1 = b;
        ifc1.start = 1'b1;
        @(posedge clk); #1;
        ifc1.start = 1'b0;
        cyc = 0;
        while (!ifc1.done && cyc < 200) begin
            ifc1.start = 1'b0;
            if (!poked && ifc1.busy && int'(ifc1.vec) == poke) begin
                ifc1.start = 1'b1;
                poked = 1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        ifc1.start = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic [15:0] ea, input logic [15:0] eb,
                                input int ecnt, input int efirst, input logic eeq);
        chk({tag, " mask_a"}, 32'(ifc1.mask_a), 32'(ea));
        chk({tag, " mask_b"}, 32'(ifc1.mask_b), 32'(eb));
        chk({tag, " mismatch_cnt"}, 32'(ifc1.mismatch_cnt), 32'(ecnt));
        chk({tag, " first_mm"}, 32'(ifc1.first_mm), 32'(efirst));
        chk({tag, " equal"}, 32'(ifc1.equal), 32'(eeq));
        chk({tag, " busy"}, 32'(ifc1.busy), 32'd0);
        chk({tag, " vec_hold"}, 32'(ifc1.vec), 32'd15);
    endtask

    initial begin
        int cyc, cnt, first, bad, n;
        logic [15:0] simpl, ra, rb;

        for (int i = 0; i < 16; i++) simpl[i] = f_simpl(4'(i));
        tbl[0] = '{"t1_simplified", simpl,    simpl, 16'h5F55, 16'h5F55, 0,  0,  1'b1};
        tbl[1] = '{"t2_pos6_vs_3",  16'h5F59, simpl, 16'h5F59, 16'h5F55, 2,  2,  1'b0};
        tbl[2] = '{"t6_all_diff",   16'hFFFF, 16'h0, 16'hFFFF, 16'h0000, 16, 0,  1'b0};
        tbl[3] = '{"last_only",     16'h8000, 16'h0, 16'h8000, 16'h0000, 1,  15, 1'b0};
        tbl[4] = '{"all_zero",      16'h0000, 16'h0, 16'h0000, 16'h0000, 0,  0,  1'b1};

        ta1 = '0; tb1 = '0; ta3 = '0; tb3 = '0;
        ifc1.start = 1'b0; ifc3.start = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        chk("rst vec", 32'(ifc1.vec), 0);
        chk("rst mask_a", 32'(ifc1.mask_a), 0);
        chk("rst mask_b", 32'(ifc1.mask_b), 0);
        chk("rst cnt", 32'(ifc1.mismatch_cnt), 0);
        chk("rst first", 32'(ifc1.first_mm), 0);
        chk("rst busy", 32'(ifc1.busy), 0);
        chk("rst done", 32'(ifc1.done), 0);
        chk("rst equal", 32'(ifc1.equal), 0);

        // Table-driven sweeps with SETTLE=1
        for (int k = 0; k < 5; k++) begin
            sweep1(tbl[k].ta, tbl[k].tb, -1, cyc);
            chk({tbl[k].name, " done_cycle"}, 32'(cyc), 32'd32);
            check_result(tbl[k].name, tbl[k].exp_a, tbl[k].exp_b,
                         tbl[k].exp_cnt, tbl[k].exp_first, tbl[k].exp_eq);
        end

        // Random truth tables against the model
        for (int r = 0; r < 8; r++) begin
            ra = 16'($urandom);
            rb = (r % 2 == 0) ? ra ^ (16'($urandom) & 16'($urandom)) : 16'($urandom);
            model(ra, rb, cnt, first);
            sweep1(ra, rb, -1, cyc);
            chk("rand done_cycle", 32'(cyc), 32'd32);
            check_result("rand", ra, rb, cnt, first, cnt == 0);
        end

        // SETTLE=3: each vector lasts 4 cycles
        ta3 = 16'hFFFF; tb3 = 16'hFFFF;
        ifc3.start = 1'b1;
        @(posedge clk); #1;
        ifc3.start = 1'b0;
        cyc = 0; bad = 0;
        while (!ifc3.done && cyc < 400) begin
            if (ifc3.busy && int'(ifc3.vec) != cyc / 4) bad++;
            @(posedge clk); #1;
            cyc++;
        end
        chk("s3 vec_pacing_errs", 32'(bad), 0);
        chk("s3 done_cycle", 32'(cyc), 32'd64);
        chk("s3 mask_a", 32'(ifc3.mask_a), 32'hFFFF);
        chk("s3 mask_b", 32'(ifc3.mask_b), 32'hFFFF);
        chk("s3 equal", 32'(ifc3.equal), 1);

        // Reset while vec==7 in APPLY aborts the sweep
        ta1 = 16'hFFFF; tb1 = 16'h0;
        ifc1.start = 1'b1;
        @(posedge clk); #1;
        ifc1.start = 1'b0;
        n = 0;
        while (ifc1.vec != 4'd7 && n < 100) begin @(posedge clk); #1; n++; end
        chk("abort reached_vec7", 32'(ifc1.vec), 7);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort vec", 32'(ifc1.vec), 0);
        chk("abort mask_a", 32'(ifc1.mask_a), 0);
        chk("abort cnt", 32'(ifc1.mismatch_cnt), 0);
        chk("abort busy", 32'(ifc1.busy), 0);
        chk("abort done", 32'(ifc1.done), 0);
        @(posedge clk); #1;
        chk("abort stays_idle", 32'(ifc1.busy), 0);

        // start while busy at vec==5 is ignored
        model(16'h5F59, simpl, cnt, first);
        sweep1(16'h5F59, simpl, 5, cyc);
        chk("busy_start done_cycle", 32'(cyc), 32'd32);
        check_result("busy_start", 16'h5F59, simpl, cnt, first, 1'b0);

        // start in DONE restarts with cleared results
        ifc1.start = 1'b1;
        @(posedge clk); #1;
        ifc1.start = 1'b0;
        chk("restart vec", 32'(ifc1.vec), 0);
        chk("restart mask_a", 32'(ifc1.mask_a), 0);
        chk("restart cnt", 32'(ifc1.mismatch_cnt), 0);
        chk("restart first", 32'(ifc1.first_mm), 0);
        chk("restart busy", 32'(ifc1.busy), 1);
        chk("restart done", 32'(ifc1.done), 0);
        chk("restart equal", 32'(ifc1.equal), 0);
        n = 0;
        while (!ifc1.done && n < 200) begin @(posedge clk); #1; n++; end
        chk("restart done_cycle", 32'(n), 32'd32);
        check_result("restart", 16'h5F59, simpl, cnt, first, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
